// File: rtl/ffra_wb_bridge.sv
// rtl/ffra_wb_bridge.sv - Wishbone-classic register bridge that launches ffra operations and returns the result
// Define FFRA_BRIDGE_IRQ_EN to add the registered completion interrupt output irq.
module ffra_wb_bridge #(
  parameter logic [31:0] BASE_ADR = 32'h3000_0000,
  parameter int unsigned LATENCY  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [7:0]  a,
  output logic [7:0]  b,
  output logic [15:0] ci,
  input  logic [15:0] o
`ifdef FFRA_BRIDGE_IRQ_EN
  ,
  output logic        irq
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  localparam logic [3:0] LAT4 = 4'(LATENCY);

  state_t      state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic [15:0] result;
  logic        capture;

  logic        in_win, req, wr, rd;
  logic [1:0]  word;
  logic [31:0] rdata;
  logic        busy, done, start, res_rd;
  logic        unused_bits;

  assign in_win = (wbs_adr_i[31:4] == BASE_ADR[31:4]);
  // ack gating guarantees an idle cycle between transfers on a held strobe
  assign req    = wbs_cyc_i & wbs_stb_i & in_win & ~wbs_ack_o;
  assign wr     = req & wbs_we_i;
  assign rd     = req & ~wbs_we_i;
  assign word   = wbs_adr_i[3:2];
  assign busy   = (state == S_WAIT);
  assign done   = (state == S_DONE);
  assign start  = wr && (word == 2'd2) && wbs_sel_i[0] && wbs_dat_i[0];
  assign res_rd = rd && (word == 2'd3);

  assign unused_bits = ^{wbs_adr_i[1:0], wbs_sel_i[3:2], wbs_dat_i[31:16]};

  always_comb begin
    rdata = '0;
    case (word)
      2'd0:    rdata = {16'h0, b, a};
      2'd1:    rdata = {16'h0, ci};
      2'd2:    rdata = {30'h0, done, busy};
      default: rdata = {16'h0, result};
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      wbs_ack_o <= req;
      wbs_dat_o <= rd ? rdata : '0;
    end
  end

  // Operands are frozen while an operation is in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      a  <= '0;
      b  <= '0;
      ci <= '0;
    end else if (wr && !busy) begin
      if (word == 2'd0) begin
        if (wbs_sel_i[0]) a <= wbs_dat_i[7:0];
        if (wbs_sel_i[1]) b <= wbs_dat_i[15:8];
      end
      if (word == 2'd1) begin
        if (wbs_sel_i[0]) ci[7:0]  <= wbs_dat_i[7:0];
        if (wbs_sel_i[1]) ci[15:8] <= wbs_dat_i[15:8];
      end
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    capture = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_n = S_WAIT;
          cnt_n   = LAT4;
        end
      end
      S_WAIT: begin
        if (cnt == 4'd1) begin
          capture = 1'b1;
          state_n = S_DONE;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      S_DONE: begin
        if (start) begin
          state_n = S_WAIT;
          cnt_n   = LAT4;
        end else if (res_rd) begin
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      result <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (capture) result <= o;
    end
  end

`ifdef FFRA_BRIDGE_IRQ_EN
  always_ff @(posedge clk) begin
    if (rst) irq <= 1'b0;
    else     irq <= (state_n == S_DONE);
  end
`endif

endmodule

// File: tb/tb_ffra_wb_bridge.sv
// tb/tb_ffra_wb_bridge.sv - self-checking bench for ffra_wb_bridge (vector table plus read-data scoreboard)
// Also builds with FFRA_BRIDGE_IRQ_EN defined, in which case irq is checked.
module tb_ffra_wb_bridge;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = 32'h0, wdat = 32'h0;
  logic        ack;
  logic [31:0] rdat;
  logic [7:0]  a, b;
  logic [15:0] ci;
  logic [15:0] o = 16'h0;
`ifdef FFRA_BRIDGE_IRQ_EN
  logic        irq;
`endif

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic        chk;
    logic [31:0] exp;
    string       name;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    logic        w;
    logic [3:0]  off;
    logic [3:0]  sel;
    logic [31:0] dat;
    logic [31:0] exp_rd;
    logic [7:0]  ea;
    logic [7:0]  eb;
    logic [15:0] eci;
  } vec_t;
  vec_t tbl[12];

  always #5 clk = ~clk;

  ffra_wb_bridge dut (
    .clk       (clk),
    .rst       (rst),
    .wbs_cyc_i (cyc),
    .wbs_stb_i (stb),
    .wbs_we_i  (we),
    .wbs_sel_i (sel),
    .wbs_adr_i (adr),
    .wbs_dat_i (wdat),
    .wbs_ack_o (ack),
    .wbs_dat_o (rdat),
    .a         (a),
    .b         (b),
    .ci        (ci),
    .o         (o)
`ifdef FFRA_BRIDGE_IRQ_EN
    ,
    .irq       (irq)
`endif
  );

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endfunction

  task automatic chk_irq(input logic exp, input string name);
`ifdef FFRA_BRIDGE_IRQ_EN
    check(name, 32'(irq), 32'(exp));
`endif
  endtask

  // Scoreboard: every ack pops one expected entry; reads compare data
  logic prev_ack = 1'b0;
  always @(negedge clk) begin : mon
    sb_t e;
    if (ack) begin
      check("ack_single_cycle", 32'(prev_ack), 32'h0);
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_ack: got ack=1 expected no ack");
      end else begin
        e = sb.pop_front();
        if (e.chk) check(e.name, rdat, e.exp);
      end
    end
    prev_ack = ack;
  end

  task automatic xfer(input logic w, input logic [31:0] ad, input logic [3:0] s, input logic [31:0] d,
                      input logic chk, input logic [31:0] exp, input string name);
    bit got;
    got = 1'b0;
    sb.push_back('{chk, exp, name});
    cyc = 1'b1; stb = 1'b1; we = w; adr = ad; sel = s; wdat = d;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk); #1;
      got = ack;
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    if (!got) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_timeout: got no ack expected ack within 8 cycles", name);
      void'(sb.pop_back());
    end
  endtask

  task automatic wr(input logic [3:0] off, input logic [3:0] s, input logic [31:0] d);
    xfer(1'b1, BASE + 32'(off), s, d, 1'b0, 32'h0, "write");
  endtask

  task automatic rd(input logic [3:0] off, input logic [31:0] exp, input string name);
    xfer(1'b0, BASE + 32'(off), 4'hF, 32'h0, 1'b1, exp, name);
  endtask

  task automatic noack(input logic [31:0] ad);
    int acks;
    acks = 0;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = ad; sel = 4'hF;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (ack) acks++;
    end
    cyc = 1'b0; stb = 1'b0;
    check("out_of_window_acks", 32'(acks), 32'h0);
  endtask

  task automatic chk_ops(input logic [7:0] ea, input logic [7:0] eb, input logic [15:0] eci, input string name);
    check({name, "_a"}, 32'(a), 32'(ea));
    check({name, "_b"}, 32'(b), 32'(eb));
    check({name, "_ci"}, 32'(ci), 32'(eci));
  endtask

  initial begin
    tbl[0]  = '{1'b1, 4'h0, 4'b0011, 32'h0000_A55A, 32'h0, 8'h5A, 8'hA5, 16'h0000};
    tbl[1]  = '{1'b0, 4'h0, 4'b1111, 32'h0,         32'h0000_A55A, 8'h5A, 8'hA5, 16'h0000};
    tbl[2]  = '{1'b1, 4'h4, 4'b0010, 32'hFFFF_1234, 32'h0, 8'h5A, 8'hA5, 16'h1200};
    tbl[3]  = '{1'b0, 4'h4, 4'b1111, 32'h0,         32'h0000_1200, 8'h5A, 8'hA5, 16'h1200};
    tbl[4]  = '{1'b1, 4'h4, 4'b0001, 32'h0000_ABCD, 32'h0, 8'h5A, 8'hA5, 16'h12CD};
    tbl[5]  = '{1'b1, 4'h4, 4'b1100, 32'hFFFF_FFFF, 32'h0, 8'h5A, 8'hA5, 16'h12CD};
    tbl[6]  = '{1'b1, 4'h0, 4'b0100, 32'h1234_5678, 32'h0, 8'h5A, 8'hA5, 16'h12CD};
    tbl[7]  = '{1'b0, 4'h0, 4'b1111, 32'h0,         32'h0000_A55A, 8'h5A, 8'hA5, 16'h12CD};
    tbl[8]  = '{1'b1, 4'hC, 4'b1111, 32'hFFFF_FFFF, 32'h0, 8'h5A, 8'hA5, 16'h12CD};
    tbl[9]  = '{1'b0, 4'hC, 4'b1111, 32'h0,         32'h0, 8'h5A, 8'hA5, 16'h12CD};
    tbl[10] = '{1'b1, 4'h8, 4'b1111, 32'hFFFF_FFFE, 32'h0, 8'h5A, 8'hA5, 16'h12CD};
    tbl[11] = '{1'b0, 4'h8, 4'b1111, 32'h0,         32'h0, 8'h5A, 8'hA5, 16'h12CD};

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_ops(8'h0, 8'h0, 16'h0, "reset");
    check("reset_ack", 32'(ack), 32'h0);
    check("reset_dat", rdat, 32'h0);
    chk_irq(1'b0, "reset_irq");
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
      xfer(tbl[i].w, BASE + 32'(tbl[i].off), tbl[i].sel, tbl[i].dat, !tbl[i].w, tbl[i].exp_rd,
           $sformatf("vec%0d_rd", i));
      chk_ops(tbl[i].ea, tbl[i].eb, tbl[i].eci, $sformatf("vec%0d", i));
    end

    // Launch: capture must take o exactly LATENCY=2 edges after the start
    o = 16'h1234;
    wr(4'h8, 4'hF, 32'h1);
    fork
      rd(4'h8, 32'h1, "status_busy");
      begin
        @(posedge clk); #1;
        chk_irq(1'b0, "irq_before_capture");
        @(posedge clk); #1;
        o = 16'hBEEF;
        chk_irq(1'b1, "irq_at_capture");
      end
    join
    rd(4'h8, 32'h2, "status_done");
    chk_irq(1'b1, "irq_held");
    rd(4'hC, 32'h0000_1234, "result_launch");
    chk_irq(1'b0, "irq_cleared_by_read");
    rd(4'h8, 32'h0, "status_idle");

    // OPS write during WAIT is dropped
    o = 16'h2222;
    wr(4'h8, 4'hF, 32'h1);
    wr(4'h0, 4'hF, 32'h0000_FFFF);
    chk_ops(8'h5A, 8'hA5, 16'h12CD, "busy_drop");
    rd(4'h8, 32'h2, "status_after_busy_write");
    rd(4'hC, 32'h0000_2222, "result_busy_write");
    rd(4'h0, 32'h0000_A55A, "ops_after_busy_write");

    // Second start during WAIT must not restart the count
    o = 16'h3333;
    wr(4'h8, 4'hF, 32'h1);
    wr(4'h8, 4'hF, 32'h1);
    o = 16'h4444;
    rd(4'h8, 32'h2, "status_after_double_start");
    rd(4'hC, 32'h0000_3333, "result_double_start");

    // RESULT read on the capture edge returns old data and done survives
    o = 16'h5555;
    wr(4'h8, 4'hF, 32'h1);
    rd(4'hC, 32'h0000_3333, "result_same_edge_old");
    rd(4'h8, 32'h2, "status_same_edge_done");
    chk_irq(1'b1, "irq_same_edge");
    o = 16'h6666;
    wr(4'h8, 4'hF, 32'h1);
    rd(4'h8, 32'h1, "status_restart_from_done");
    rd(4'hC, 32'h0000_6666, "result_restart_from_done");
    rd(4'h8, 32'h0, "status_idle2");

    // Reset one edge after a start aborts everything
    wr(4'h0, 4'hF, 32'h0000_C33C);
    wr(4'h4, 4'hF, 32'h0000_BEEF);
    chk_ops(8'h3C, 8'hC3, 16'hBEEF, "pre_reset");
    o = 16'h7777;
    wr(4'h8, 4'hF, 32'h1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_ops(8'h0, 8'h0, 16'h0, "mid_wait_reset");
    check("mid_wait_reset_ack", 32'(ack), 32'h0);
    check("mid_wait_reset_dat", rdat, 32'h0);
    chk_irq(1'b0, "mid_wait_reset_irq");
    repeat (4) @(posedge clk);
    #1;
    chk_irq(1'b0, "irq_no_capture_after_reset");
    rd(4'h8, 32'h0, "status_after_reset");
    rd(4'hC, 32'h0, "result_after_reset");

    noack(BASE + 32'h10);

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000 time units");
    $fatal(1);
  end

endmodule
